// File: rtl/cv32e40p_ft_fault_monitor.sv
// Fault monitor for a triplicated (TMR) functional unit.
// Each replica has a leaky-bucket error counter. Mismatches attributed to a
// replica increment its counter, and clean samples decrement it by DECAY.
// A replica whose counter reaches THRESHOLD is latched FAULTY until software
// clears it.
//
// Handshake: sample_i qualifies err_* for one cycle; there is no ready, and
// every asserted sample_i is consumed on the same rising edge.
module cv32e40p_ft_fault_monitor #(
  parameter int CNT_W     = 8,
  parameter int THRESHOLD = 100,
  parameter int DECAY     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_i,
  input  logic [2:0]            err_replica_i,
  input  logic                  err_detected_i,
  input  logic                  err_corrected_i,
  input  logic [2:0]            clear_i,
  output logic [2:0][CNT_W-1:0] cnt_o,
  output logic [2:0]            faulty_o,
  output logic                  degraded_o,
  output logic                  fatal_o,
  output logic                  perf_corrected_o,
  output logic                  perf_uncorrectable_o,
  output logic [2:0]            perf_permanent_o,
  output logic [2:0][1:0]       fsm_state_o
);

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] DEC     = CNT_W'(DECAY);

  state_e                 state_q [3];
  state_e                 state_d [3];
  logic [2:0][CNT_W-1:0]  cnt_q;
  logic [2:0][CNT_W-1:0]  cnt_d;
  logic [2:0][CNT_W-1:0]  upd;
  logic [2:0]             enter_d;
  logic [2:0]             perm_q;
  logic                   corr_q;
  logic                   uncorr_q;
  logic                   corrected;
  logic                   uncorrectable;

  // An uncorrectable disagreement cannot be pinned on any replica.
  assign corrected     = sample_i & err_detected_i & err_corrected_i;
  assign uncorrectable = sample_i & err_detected_i & ~err_corrected_i;

  // Per-replica next state: clear, then FAULTY freeze, then sample update.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      upd[k]     = cnt_q[k];
      enter_d[k] = 1'b0;
      if (clear_i[k]) begin
        cnt_d[k]   = '0;
        state_d[k] = HEALTHY;
      end else if (state_q[k] == FAULTY) begin
        cnt_d[k]   = cnt_q[k];
      end else if (sample_i && !uncorrectable) begin
        if (err_replica_i[k]) begin
          upd[k] = (cnt_q[k] == CNT_MAX) ? CNT_MAX : cnt_q[k] + 1'b1;
        end else begin
          upd[k] = (cnt_q[k] >= DEC) ? cnt_q[k] - DEC : '0;
        end
        cnt_d[k] = upd[k];
        if (upd[k] >= THR) begin
          state_d[k] = FAULTY;
          enter_d[k] = 1'b1;
        end else if (upd[k] == '0) begin
          state_d[k] = HEALTHY;
        end else begin
          state_d[k] = SUSPECT;
        end
      end
    end
  end

  // State, counter and event-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= HEALTHY;
      end
      cnt_q    <= '0;
      perm_q   <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
      end
      cnt_q    <= cnt_d;
      perm_q   <= enter_d;
      corr_q   <= corrected;
      uncorr_q <= uncorrectable;
    end
  end

  // Status flags decoded from registered state only.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      faulty_o[k]    = (state_q[k] == FAULTY);
      fsm_state_o[k] = state_q[k];
    end
    degraded_o = |faulty_o;
    fatal_o    = (faulty_o[0] & faulty_o[1]) | (faulty_o[0] & faulty_o[2]) |
                 (faulty_o[1] & faulty_o[2]);
  end

  assign cnt_o                = cnt_q;
  assign perf_permanent_o     = perm_q;
  assign perf_corrected_o     = corr_q;
  assign perf_uncorrectable_o = uncorr_q;

endmodule

// File: tb/tb_cv32e40p_ft_fault_monitor.sv
// Bench for cv32e40p_ft_fault_monitor: two instances (THRESHOLD 100 and 255)
// share one stimulus stream and are compared against a counter/flag model.
module tb_cv32e40p_ft_fault_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sample_i;
  logic [2:0] err_replica_i;
  logic       err_detected_i;
  logic       err_corrected_i;
  logic [2:0] clear_i;

  logic [2:0][7:0] o_cnt    [2];
  logic [2:0]      o_faulty [2];
  logic            o_deg    [2];
  logic            o_fatal  [2];
  logic            o_pc     [2];
  logic            o_pu     [2];
  logic [2:0]      o_perm   [2];
  logic [2:0][1:0] o_state  [2];

  cv32e40p_ft_fault_monitor #(.CNT_W(8), .THRESHOLD(100), .DECAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .err_replica_i(err_replica_i),
    .err_detected_i(err_detected_i), .err_corrected_i(err_corrected_i), .clear_i(clear_i),
    .cnt_o(o_cnt[0]), .faulty_o(o_faulty[0]), .degraded_o(o_deg[0]), .fatal_o(o_fatal[0]),
    .perf_corrected_o(o_pc[0]), .perf_uncorrectable_o(o_pu[0]),
    .perf_permanent_o(o_perm[0]), .fsm_state_o(o_state[0])
  );

  cv32e40p_ft_fault_monitor #(.CNT_W(8), .THRESHOLD(255), .DECAY(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .err_replica_i(err_replica_i),
    .err_detected_i(err_detected_i), .err_corrected_i(err_corrected_i), .clear_i(clear_i),
    .cnt_o(o_cnt[1]), .faulty_o(o_faulty[1]), .degraded_o(o_deg[1]), .fatal_o(o_fatal[1]),
    .perf_corrected_o(o_pc[1]), .perf_uncorrectable_o(o_pu[1]),
    .perf_permanent_o(o_perm[1]), .fsm_state_o(o_state[1])
  );

  // ---------------- reference model ----------------
  int thr    [2] = '{100, 255};
  int m_cnt  [2][3];
  bit m_f    [2][3];
  bit m_perm [2][3];
  bit m_pc;
  bit m_pu;

  int checks = 0;
  int errors = 0;

  // Applies the bucket rules to the inputs present at the edge just taken.
  task automatic model_update();
    bit unc;
    unc  = sample_i & err_detected_i & ~err_corrected_i;
    m_pc = rst_n & sample_i & err_detected_i & err_corrected_i;
    m_pu = rst_n & unc;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        m_perm[i][k] = 1'b0;
        if (!rst_n || clear_i[k]) begin
          m_cnt[i][k] = 0;
          m_f[i][k]   = 1'b0;
        end else if (!m_f[i][k] && sample_i && !unc) begin
          if (err_replica_i[k]) m_cnt[i][k] = (m_cnt[i][k] + 1 > 255) ? 255 : m_cnt[i][k] + 1;
          else                  m_cnt[i][k] = (m_cnt[i][k] - 2 < 0) ? 0 : m_cnt[i][k] - 2;
          if (m_cnt[i][k] >= thr[i]) begin
            m_f[i][k]    = 1'b1;
            m_perm[i][k] = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] e_cnt;
    logic [2:0]  e_f;
    logic [2:0]  e_p;
    int          nf;
    for (int i = 0; i < 2; i++) begin
      nf = 0;
      for (int k = 0; k < 3; k++) begin
        e_cnt[k*8 +: 8] = 8'(m_cnt[i][k]);
        e_f[k]          = m_f[i][k];
        e_p[k]          = m_perm[i][k];
        nf             += int'(m_f[i][k]);
      end
      chk($sformatf("%s[%0d].cnt", tag, i),    32'(o_cnt[i]),    32'(e_cnt));
      chk($sformatf("%s[%0d].faulty", tag, i), 32'(o_faulty[i]), 32'(e_f));
      chk($sformatf("%s[%0d].degraded", tag, i), 32'(o_deg[i]),  32'(nf >= 1));
      chk($sformatf("%s[%0d].fatal", tag, i),  32'(o_fatal[i]),  32'(nf >= 2));
      chk($sformatf("%s[%0d].perf_corr", tag, i), 32'(o_pc[i]),  32'(m_pc));
      chk($sformatf("%s[%0d].perf_unc", tag, i),  32'(o_pu[i]),  32'(m_pu));
      chk($sformatf("%s[%0d].perf_perm", tag, i), 32'(o_perm[i]), 32'(e_p));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit rst, input bit s, input bit [2:0] rep,
                      input bit det, input bit corr, input bit [2:0] clr);
    rst_n           = rst;
    sample_i        = s;
    err_replica_i   = rep;
    err_detected_i  = det;
    err_corrected_i = corr;
    clear_i         = clr;
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  int pct [3] = '{80, 30, 60};

  initial begin
    bit [2:0] rep;
    bit [2:0] clr;
    bit       s;
    bit       det;
    bit       corr;
    bit       rst;

    // reset state
    step("reset0", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000);
    step("reset1", 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 3'b000);

    // threshold: replica 0 climbs to 100, then stays frozen
    for (int n = 0; n < 103; n++) step("thresh", 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'b000);

    // decay: replica 1 to 5, then four clean samples
    step("clr_all", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111);
    for (int n = 0; n < 5; n++) step("decay_up", 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 3'b000);
    for (int n = 0; n < 4; n++) step("decay_dn", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000);

    // saturation on the THRESHOLD=255 instance
    step("clr_all", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111);
    for (int n = 0; n < 256; n++) step("sat", 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'b000);

    // clear beats a concurrent attributed error on a FAULTY replica
    step("clr_prio", 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001);
    step("clr_prio2", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000);

    // fatal: replicas 0 then 2 go FAULTY; clearing 2 leaves degraded
    step("clr_all", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111);
    for (int n = 0; n < 100; n++) step("fatal_r0", 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'b000);
    for (int n = 0; n < 101; n++) step("fatal_r2", 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 3'b000);
    step("fatal_clr", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100);

    // uncorrectable: no counter moves
    for (int n = 0; n < 3; n++) step("unc_pre", 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 3'b000);
    step("uncorr", 1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 3'b000);
    step("uncorr_after", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      s   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        rep[k] = ($urandom_range(0, 99) < pct[k]);
        clr[k] = ($urandom_range(0, 79) == 0);
      end
      det  = (rep != 3'b000) ? 1'b1 : ($urandom_range(0, 9) == 0);
      corr = ($urandom_range(0, 9) != 0);
      step("rand", rst, s, rep, det, corr, clr);
    end

    // reset after arbitrary activity
    step("reset_end", 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 3'b000);
    step("reset_end2", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ft_fault_monitor.md
CV32E40P_FT_FAULT_MONITOR -- requirements
Module: cv32e40p_ft_fault_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-replica error counter.
REQ-002 SHALL have parameter THRESHOLD, default 100: counter value at which a replica is declared permanently faulty; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter DECAY, default 2: counter decrement per clean sample; legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port sample_i  input  1  the voted replicated unit (e.g. multiplier TMR) produced a valid comparison this cycle.
REQ-007 SHALL have port err_replica_i  input  3  per-replica mismatch flags from the voters; bit k = replica k disagreed.
REQ-008 SHALL have port err_detected_i  input  1  any voter disagreement this cycle.
REQ-009 SHALL have port err_corrected_i  input  1  disagreement was outvoted (majority existed).
REQ-010 SHALL have port clear_i  input  3  per-replica software clear request, one-cycle pulse.
REQ-011 SHALL have port cnt_o  output  3xCNT_W  current error counter per replica.
REQ-012 SHALL have port faulty_o  output  3  sticky permanent-fault flag per replica.
REQ-013 SHALL have port degraded_o  output  1  at least one replica faulty.
REQ-014 SHALL have port fatal_o  output  1  two or more replicas faulty (majority vote no longer trustworthy).
REQ-015 SHALL have port perf_corrected_o  output  1  one-cycle pulse per corrected error event.
REQ-016 SHALL have port perf_uncorrectable_o  output  1  one-cycle pulse per uncorrectable error event.
REQ-017 SHALL have port perf_permanent_o  output  3  one-cycle pulse when replica k enters FAULTY.

Function
REQ-018 SHALL keep one independent 3-state FSM per replica: HEALTHY (cnt=0), SUSPECT (0<cnt<THRESHOLD), FAULTY.
REQ-019 SHALL, per replica, evaluate on each rising edge in priority order: clear_i[k]; FAULTY hold; sample update; hold.
REQ-020 SHALL, on clear_i[k]=1, load cnt=0 and state HEALTHY regardless of state or concurrent sample_i/err_replica_i[k].
REQ-021 SHALL, in FAULTY without clear, freeze cnt and ignore all samples.
REQ-022 SHALL define uncorrectable = sample_i & err_detected_i & ~err_corrected_i; on an uncorrectable cycle no counter changes (error cannot be attributed).
REQ-023 SHALL, on sample_i=1, not uncorrectable, err_replica_i[k]=1: cnt <= cnt+1, saturating at 2^CNT_W-1.
REQ-024 SHALL, on sample_i=1, not uncorrectable, err_replica_i[k]=0: cnt <= max(cnt-DECAY, 0), no underflow.
REQ-025 SHALL, when sample_i=0, hold cnt and state.
REQ-026 SHALL move HEALTHY/SUSPECT to FAULTY on the same edge where the updated cnt >= THRESHOLD; otherwise state follows cnt (0 -> HEALTHY, else SUSPECT).
REQ-027 SHALL handle multiple err_replica_i bits set in a correctable cycle by updating each affected counter in parallel.
REQ-028 SHALL register perf_permanent_o[k] high for exactly the cycle after the FAULTY-entry edge; re-entry after clear pulses again.
REQ-029 SHALL register perf_corrected_o high the cycle after sample_i & err_detected_i & err_corrected_i; perf_uncorrectable_o high the cycle after an uncorrectable cycle; both low otherwise.
REQ-030 SHALL derive faulty_o, degraded_o (OR of faulty_o), fatal_o (popcount(faulty_o)>=2) from registered state, valid the cycle after the state edge, no combinational path from inputs.
REQ-031 SHALL drive cnt_o directly from counter registers.

Reset
REQ-032 SHALL, on rising edge with rst_n=0, set all counters 0, all FSMs HEALTHY, all outputs 0; rst_n has priority over every input, including mid-count or in FAULTY.
REQ-033 SHALL not react to rst_n between clock edges.

Verification
REQ-034 Reset: rst_n=0 one edge after arbitrary activity -> cnt_o all 0, faulty_o=000, all pulses/flags 0 next cycle.
REQ-035 Threshold: 100 consecutive samples, err_replica_i=001, err_corrected_i=1 -> cnt_o[0] 1..100, faulty_o=001 after 100th edge, perf_permanent_o=001 one cycle, degraded_o=1, further samples leave cnt_o[0]=100.
REQ-036 Decay: cnt_o[1]=5, three clean samples -> 3, 1, 0; fourth clean sample -> 0 (no wrap); cnt=255 with CNT_W=8, THRESHOLD=255 exempt: saturation check with THRESHOLD>255 illegal, use cnt at 254+2 errors under THRESHOLD=255 -> FAULTY at 255, no wrap.
REQ-037 Clear priority: replica 0 FAULTY, same cycle clear_i=001 and sample with err_replica_i=001 -> cnt_o[0]=0, faulty_o[0]=0, no perf_permanent_o pulse.
REQ-038 Fatal: drive replicas 0 and 2 to THRESHOLD -> fatal_o=1 after second FAULTY entry; clear_i=100 -> fatal_o=0, degraded_o=1.
REQ-039 Uncorrectable: sample_i=1, err_detected_i=1, err_corrected_i=0, err_replica_i=111 -> perf_uncorrectable_o pulse next cycle, all cnt_o unchanged, perf_corrected_o=0.
